logic_unit_acc: RTL and testbench

Parametrised, registered successor to the single-bit 2-input OR gate. Applies one of eight selectable bitwise operations to WIDTH-bit operands A and B, with a valid/ready handshake on input and output. Adds an accumulate mode that folds ACC_LEN consecutive operands into one result. Intended as the reusable logic stage for later ALU labs.

---
 rtl/logic_unit_acc_pkg.sv | 21 ++
 rtl/logic_op_core.sv | 28 ++
 rtl/logic_unit_acc.sv | 130 +++++++++++++
 tb/tb_logic_unit_acc.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_acc_pkg.sv
// Shared op-code and FSM state encodings for the logic unit and its op core.
package logic_unit_acc_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_PASS = 3'd6,
        OP_NOT  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/logic_op_core.sv
// Bitwise operator z = f(x, y, op); purely combinational, no flow control.
module logic_op_core
    import logic_unit_acc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] z
);

    always_comb begin
        z = x;
        case (op_e'(op))
            OP_AND:  z = x & y;
            OP_OR:   z = x | y;
            OP_XOR:  z = x ^ y;
            OP_NAND: z = ~(x & y);
            OP_NOR:  z = ~(x | y);
            OP_XNOR: z = ~(x ^ y);
            OP_PASS: z = x;
            OP_NOT:  z = ~x;
            default: z = x;
        endcase
    end

endmodule

// File: rtl/logic_unit_acc.sv
// Registered bitwise logic stage with optional ACC_LEN-beat accumulate; 1-cycle latency.
// in_ready drops only while a result is held and out_ready is low.
module logic_unit_acc
    import logic_unit_acc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ACC_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              A,
    input  logic [WIDTH-1:0]              B,
    input  logic [2:0]                    op,
    input  logic                          mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              Y,
    output logic                          busy,
    output logic [$clog2(ACC_LEN+1)-1:0]  beat_cnt,
    output logic [CNT_W-1:0]              res_cnt
);

    localparam int              BW        = $clog2(ACC_LEN + 1);
    localparam logic [BW-1:0]   BEAT_ONE  = BW'(1);
    localparam logic [BW-1:0]   BEAT_LAST = BW'(ACC_LEN - 1);
    localparam bit              SINGLE    = (ACC_LEN == 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [2:0]         op_l_q, op_l_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [CNT_W-1:0]   res_q, res_d;

    logic               in_acc;
    logic               accept;
    logic               deliver;
    logic [WIDTH-1:0]   core_x, core_y, core_z;
    logic [2:0]         core_op;

    assign in_acc    = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_OUT);
    assign in_ready  = (state_q != ST_OUT) || out_ready;
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    // While accumulating the fold is f(acc, A, op_l), so both operand ports
    // are steered: acc moves to x and A moves to y (matters for PASS/NOT).
    assign core_x  = in_acc ? acc_q  : A;
    assign core_y  = in_acc ? A      : B;
    assign core_op = in_acc ? op_l_q : op;

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .x  (core_x),
        .y  (core_y),
        .op (core_op),
        .z  (core_z)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        acc_d   = acc_q;
        op_l_d  = op_l_q;
        beat_d  = beat_q;
        res_d   = res_q;

        if (deliver) begin
            res_d = res_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_OUT: begin
                if (accept) begin
                    if (!mode || SINGLE) begin
                        y_d     = core_z;
                        state_d = ST_OUT;
                    end else begin
                        acc_d   = core_z;
                        op_l_d  = op;
                        beat_d  = BEAT_ONE;
                        state_d = ST_ACC;
                    end
                end else if (state_q == ST_OUT && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (accept) begin
                    if (beat_q == BEAT_LAST) begin
                        y_d     = core_z;
                        beat_d  = '0;
                        state_d = ST_OUT;
                    end else begin
                        acc_d  = core_z;
                        beat_d = beat_q + BEAT_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            acc_q   <= '0;
            op_l_q  <= '0;
            beat_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            op_l_q  <= op_l_d;
            beat_q  <= beat_d;
            res_q   <= res_d;
        end
    end

    assign Y        = y_q;
    assign busy     = in_acc;
    assign beat_cnt = beat_q;
    assign res_cnt  = res_q;

endmodule

// File: tb/tb_logic_unit_acc.sv
// Scoreboard bench for logic_unit_acc (WIDTH=8, ACC_LEN=4, CNT_W=2 so res_cnt wraps).
module tb_logic_unit_acc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A, B;
    logic [2:0] op;
    logic       mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Y;
    logic       busy;
    logic [2:0] beat_cnt;
    logic [1:0] res_cnt;

    logic_unit_acc #(.WIDTH(8), .ACC_LEN(4), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .busy      (busy),
        .beat_cnt  (beat_cnt),
        .res_cnt   (res_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    logic [1:0] exp_res = 2'd0;
    int         n_chk = 0;
    int         n_err = 0;

    logic [7:0] or_a[4]  = '{8'h00, 8'h00, 8'hFF, 8'hF0};
    logic [7:0] or_b[4]  = '{8'h00, 8'hFF, 8'h00, 8'h0F};
    logic [7:0] or_y[4]  = '{8'h00, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] ops_y[8] = '{8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99, 8'hCC, 8'h33};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offer one beat from a negedge; push the expected result when the beat is
    // the one that completes a result, and optionally check 1-cycle latency.
    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                        input logic m, input bit push, input logic [7:0] exp_y,
                        input bit chk_lat);
        int waited;
        @(negedge clk);
        A = a; B = b; op = o; mode = m; in_valid = 1'b1;
        #1;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (push) exp_q.push_back(exp_y);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 'x;
        B = 'x;
        if (chk_lat) chk("latency_vld", 32'(out_valid), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Output monitor: pop and compare on each delivery, then track res_cnt.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 32'(Y), 32'hFFFF_FFFF);
                else                   chk("y", 32'(Y), 32'(exp_q.pop_front()));
                exp_res = exp_res + 2'd1;
            end
            @(posedge clk);
            #1;
            chk("res_cnt", 32'(res_cnt), 32'(exp_res));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        in_valid = 1'b0; A = '0; B = '0; op = '0; mode = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_y",        32'(Y),         32'h00);
        chk("rst_out_vld",  32'(out_valid), 32'd0);
        chk("rst_busy",     32'(busy),      32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt),  32'd0);
        chk("rst_res_cnt",  32'(res_cnt),   32'd0);
        chk("rst_in_rdy",   32'(in_ready),  32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) beat(or_a[i], or_b[i], 3'd1, 1'b0, 1'b1, or_y[i], 1'b1);
        idle(3);

        for (int i = 0; i < 8; i++) beat(8'hCC, 8'hAA, 3'(i), 1'b0, 1'b1, ops_y[i], 1'b1);
        idle(3);

        // Backpressure: first beat taken, second held off until out_ready rises.
        @(negedge clk);
        out_ready = 1'b0;
        beat(8'h3C, 8'h0F, 3'd1, 1'b0, 1'b1, 8'h3F, 1'b1);
        @(negedge clk);
        A = 8'h3C; B = 8'h0F; op = 3'd0; mode = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_in_rdy", 32'(in_ready),  32'd0);
            chk("bp_vld",    32'(out_valid), 32'd1);
            chk("bp_y_hold", 32'(Y),         32'h3F);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(in_ready), 32'd1);
        exp_q.push_back(8'h0C);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_no_bubble_vld", 32'(out_valid), 32'd1);
        chk("bp_second_y",      32'(Y),         32'h0C);
        idle(3);

        // Accumulate XOR; op changes on beats 3/4 must be ignored.
        beat(8'h01, 8'h10, 3'd2, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("acc_busy1", 32'(busy), 32'd1);
        chk("acc_beat1", 32'(beat_cnt), 32'd1);
        beat(8'h02, 8'hFF, 3'd2, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("acc_busy2", 32'(busy), 32'd1);
        chk("acc_beat2", 32'(beat_cnt), 32'd2);
        beat(8'h04, 8'hFF, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("acc_busy3", 32'(busy), 32'd1);
        chk("acc_beat3", 32'(beat_cnt), 32'd3);
        beat(8'h08, 8'hFF, 3'd5, 1'b0, 1'b1, 8'h1F, 1'b1);
        chk("acc_busy_done", 32'(busy), 32'd0);
        chk("acc_beat_done", 32'(beat_cnt), 32'd0);
        chk("acc_y",         32'(Y), 32'h1F);
        idle(3);

        // Asynchronous reset mid-accumulation, then a fresh XNOR accumulation.
        beat(8'h55, 8'h00, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0);
        beat(8'h0A, 8'h00, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("mid_beat2", 32'(beat_cnt), 32'd2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_res = 2'd0;
        #1;
        chk("arst_out_vld",  32'(out_valid), 32'd0);
        chk("arst_y",        32'(Y),         32'h00);
        chk("arst_busy",     32'(busy),      32'd0);
        chk("arst_beat_cnt", 32'(beat_cnt),  32'd0);
        chk("arst_res_cnt",  32'(res_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(8'h0F, 8'hF0, 3'd5, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("fresh_beat1", 32'(beat_cnt), 32'd1);
        beat(8'h33, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        beat(8'h0F, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        beat(8'h81, 8'h00, 3'd0, 1'b0, 1'b1, 8'h42, 1'b1);
        idle(4);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
